rprog_ramp_sequencer: RTL and testbench

//   Sequences the 4-bit resistor-programming code (r_prog) that feeds the resistor decoder.

---
 rtl/rprog_pkg.sv | 19 +
 rtl/rprog_interval_timer.sv | 35 +++
 rtl/rprog_ramp_sequencer.sv | 150 +++++++++++++++
 tb/tb_rprog_ramp_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rprog_pkg.sv
// Shared types and constants for the r_prog ramp sequencer.
package rprog_pkg;

    typedef logic [3:0] rprog_code_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        SETTLE = 2'd2
    } rprog_state_t;

    localparam rprog_code_t RPROG_MAX = 4'd15;

    // Wide enough to hold the longer of the step and settle intervals.
    function automatic int tmr_width(input int step_cycles, input int settle_cycles);
        return $clog2(((step_cycles > settle_cycles) ? step_cycles : settle_cycles) + 1);
    endfunction

endpackage

// File: rtl/rprog_interval_timer.sv
// Loadable down-counter shared by the RAMP step interval and the SETTLE interval.
module rprog_interval_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_value_i,
    input  logic         dec_en_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (dec_en_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/rprog_ramp_sequencer.sv
// Ramps r_prog one LSB per STEP_CYCLES toward a requested code, then settles and pulses done.
// Optional RPROG_RETARGET_EN lets a new request supersede one that is still ramping or settling.
module rprog_ramp_sequencer
    import rprog_pkg::*;
#(
    parameter int          STEP_CYCLES   = 16,
    parameter int          SETTLE_CYCLES = 64,
    parameter rprog_code_t RESET_CODE    = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_code,
    input  logic       hold,
    output logic [3:0] r_prog,
    output logic       busy,
    output logic       done
);

    localparam int TMR_W = tmr_width(STEP_CYCLES, SETTLE_CYCLES);
    localparam logic [TMR_W-1:0] STEP_LOAD   = TMR_W'(STEP_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

    rprog_state_t state_q, state_d;
    rprog_code_t  r_prog_q, r_prog_d;
    rprog_code_t  target_q, target_d;
    logic         dirUp_q, dirUp_d;
    logic         done_q, done_d;

    logic             tmrLoad;
    logic [TMR_W-1:0] tmrLoadValue;
    logic             tmrDec;
    logic             tmrZero;
    logic             accept;
    logic             atLimit;
    rprog_code_t      stepCode;

    rprog_interval_timer #(.W(TMR_W)) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (tmrLoad),
        .load_value_i (tmrLoadValue),
        .dec_en_i     (tmrDec),
        .zero_o       (tmrZero)
    );

`ifdef RPROG_RETARGET_EN
    assign req_ready = 1'b1;
`else
    assign req_ready = (state_q == IDLE);
`endif

    assign accept = req_valid && req_ready;

    // Clamp at the rails so r_prog can never wrap even on an inconsistent target.
    assign atLimit  = dirUp_q ? (r_prog_q == RPROG_MAX) : (r_prog_q == '0);
    assign stepCode = atLimit ? r_prog_q : (dirUp_q ? r_prog_q + 4'd1 : r_prog_q - 4'd1);

    always_comb begin
        state_d      = state_q;
        r_prog_d     = r_prog_q;
        target_d     = target_q;
        dirUp_d      = dirUp_q;
        done_d       = 1'b0;
        tmrLoad      = 1'b0;
        tmrLoadValue = STEP_LOAD;
        tmrDec       = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_code == r_prog_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = req_code;
                        dirUp_d  = (req_code > r_prog_q);
                        tmrLoad  = 1'b1;
                        state_d  = RAMP;
                    end
                end
            end
            RAMP: begin
                if (!hold) begin
                    if (!tmrZero) begin
                        tmrDec = 1'b1;
                    end else begin
                        r_prog_d = stepCode;
                        tmrLoad  = 1'b1;
                        if ((stepCode == target_q) || atLimit) begin
                            tmrLoadValue = SETTLE_LOAD;
                            state_d      = SETTLE;
                        end
                    end
                end
            end
            SETTLE: begin
                if (!hold) begin
                    if (!tmrZero) begin
                        tmrDec = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef RPROG_RETARGET_EN
        // A new request wins over any step or done scheduled on the same edge.
        if (accept && (state_q != IDLE)) begin
            target_d = req_code;
            dirUp_d  = (req_code > r_prog_q);
            r_prog_d = r_prog_q;
            done_d   = 1'b0;
            tmrDec   = 1'b0;
            tmrLoad  = 1'b1;
            if (req_code == r_prog_q) begin
                tmrLoadValue = SETTLE_LOAD;
                state_d      = SETTLE;
            end else begin
                tmrLoadValue = STEP_LOAD;
                state_d      = RAMP;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            r_prog_q <= RESET_CODE;
            target_q <= RESET_CODE;
            dirUp_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_prog_q <= r_prog_d;
            target_q <= target_d;
            dirUp_q  <= dirUp_d;
            done_q   <= done_d;
        end
    end

    assign r_prog = r_prog_q;
    assign done   = done_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_rprog_ramp_sequencer.sv
// Self-checking bench for rprog_ramp_sequencer against an elapsed-time reference model.
module tb_rprog_ramp_sequencer;

    localparam int         STEP       = 4;
    localparam int         SETTLE     = 8;
    localparam logic [3:0] RESET_CODE = 4'd0;
`ifdef RPROG_RETARGET_EN
    localparam bit RETARGET = 1'b1;
`else
    localparam bit RETARGET = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_code;
    logic       hold;
    logic [3:0] r_prog;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    // Reference model: a request is a start code, a target and an elapsed (unheld) cycle count.
    int mStart  = 0;
    int mTarget = 0;
    int mEff    = 0;
    int mRprog  = 0;
    bit mActive = 1'b0;
    bit mDone   = 1'b0;

    rprog_ramp_sequencer #(
        .STEP_CYCLES   (STEP),
        .SETTLE_CYCLES (SETTLE),
        .RESET_CODE    (RESET_CODE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_code  (req_code),
        .hold      (hold),
        .r_prog    (r_prog),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Advance one clock edge, update the model from the inputs seen at that edge, settle 1ns.
    task automatic clockEdge();
        bit wasActive;
        bit acc;
        int n;
        int k;
        @(posedge clk);
        wasActive = mActive;
        acc       = req_valid && (RETARGET || !wasActive);
        mDone     = 1'b0;
        if (!rst_n) begin
            mActive = 1'b0;
            mRprog  = int'(RESET_CODE);
        end else if (acc && wasActive) begin
            mStart  = mRprog;
            mTarget = int'(req_code);
            mEff    = 0;
        end else if (wasActive && !hold) begin
            mEff++;
            n      = (mTarget > mStart) ? mTarget - mStart : mStart - mTarget;
            k      = ((mEff / STEP) < n) ? (mEff / STEP) : n;
            mRprog = (mTarget > mStart) ? mStart + k : mStart - k;
            if (mEff == n * STEP + SETTLE) begin
                mActive = 1'b0;
                mDone   = 1'b1;
            end
        end else if (acc) begin
            if (int'(req_code) == mRprog) begin
                mDone = 1'b1;
            end else begin
                mStart  = mRprog;
                mTarget = int'(req_code);
                mEff    = 0;
                mActive = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_code = 4'd0; hold = 1'b0;
        clockEdge();
        clockEdge();
        checks++; if (r_prog !== RESET_CODE) begin errors++; $display("[TB] FAIL reset_rprog got=%0d exp=%0d", r_prog, RESET_CODE); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", req_ready); end
        rst_n = 1'b1;
        clockEdge();
    endtask

    task automatic test_ramp_up();
        int doneCount = 0;
        req_valid = 1'b1; req_code = 4'd5;
        clockEdge();
        req_valid = 1'b0;
        for (int i = 1; i <= 34; i++) begin
            clockEdge();
            doneCount += int'(done);
            checks++; if (r_prog !== 4'(mRprog)) begin errors++; $display("[TB] FAIL up_rprog i=%0d got=%0d exp=%0d", i, r_prog, mRprog); end
            checks++; if (busy !== mActive) begin errors++; $display("[TB] FAIL up_busy i=%0d got=%b exp=%b", i, busy, mActive); end
            checks++; if (done !== mDone) begin errors++; $display("[TB] FAIL up_done i=%0d got=%b exp=%b", i, done, mDone); end
            checks++; if (req_ready !== (RETARGET || !mActive)) begin errors++; $display("[TB] FAIL up_ready i=%0d got=%b", i, req_ready); end
            if ((i % 4 == 0) && (i <= 20)) begin
                checks++; if (r_prog !== 4'(i / 4)) begin errors++; $display("[TB] FAIL up_step i=%0d got=%0d exp=%0d", i, r_prog, i / 4); end
            end
            if (i == 28) begin
                checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL up_done_t28 got=%b exp=1", done); end
            end
        end
        checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL up_done_count got=%0d exp=1", doneCount); end
    endtask

    task automatic test_same_code();
        req_valid = 1'b1; req_code = 4'd5;
        clockEdge();
        req_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL same_done got=%b exp=1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL same_busy got=%b exp=0", busy); end
        for (int i = 1; i <= 4; i++) begin
            clockEdge();
            checks++; if (busy !== 1'b0 || done !== 1'b0 || r_prog !== 4'd5) begin
                errors++; $display("[TB] FAIL same_after i=%0d busy=%b done=%b rprog=%0d exp 0/0/5", i, busy, done, r_prog);
            end
        end
    endtask

    task automatic test_ramp_down();
        req_valid = 1'b1; req_code = 4'd2;
        clockEdge();
        req_valid = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            clockEdge();
            checks++; if (r_prog !== 4'(mRprog)) begin errors++; $display("[TB] FAIL down_rprog i=%0d got=%0d exp=%0d", i, r_prog, mRprog); end
            checks++; if (done !== mDone || busy !== mActive) begin errors++; $display("[TB] FAIL down_flags i=%0d done=%b busy=%b exp %b/%b", i, done, busy, mDone, mActive); end
            checks++; if (r_prog < 4'd2 || r_prog > 4'd5) begin errors++; $display("[TB] FAIL down_range i=%0d got=%0d", i, r_prog); end
            if (i == 20) begin
                checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL down_done_t20 got=%b exp=1", done); end
            end
        end
    endtask

    task automatic test_hold();
        rst_n = 1'b0;
        clockEdge();
        rst_n = 1'b1;
        req_valid = 1'b1; req_code = 4'd15;
        clockEdge();
        req_valid = 1'b0;
        for (int i = 1; i <= 84; i++) begin
            clockEdge();
            hold = (i >= 12 && i < 22);
            checks++; if (r_prog !== 4'(mRprog)) begin errors++; $display("[TB] FAIL hold_rprog i=%0d got=%0d exp=%0d", i, r_prog, mRprog); end
            checks++; if (done !== mDone || busy !== mActive) begin errors++; $display("[TB] FAIL hold_flags i=%0d done=%b busy=%b exp %b/%b", i, done, busy, mDone, mActive); end
            if (i == 25 || i == 26) begin
                checks++; if (r_prog !== 4'(i - 22)) begin errors++; $display("[TB] FAIL hold_shift i=%0d got=%0d exp=%0d", i, r_prog, i - 22); end
            end
            if (i == 78) begin
                checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL hold_done_t78 got=%b exp=1", done); end
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_reset_mid_ramp();
        req_valid = 1'b1; req_code = 4'd10;
        clockEdge();
        req_valid = 1'b0;
        for (int i = 1; i <= 7; i++) clockEdge();
        rst_n = 1'b0;
        clockEdge();
        rst_n = 1'b1;
        checks++; if (r_prog !== RESET_CODE || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_state rprog=%0d busy=%b done=%b exp 0/0/0", r_prog, busy, done);
        end
        for (int i = 1; i <= 30; i++) begin
            clockEdge();
            checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_nodone i=%0d got=%b exp=0", i, done); end
        end
        req_valid = 1'b1; req_code = 4'd1;
        clockEdge();
        req_valid = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            clockEdge();
            checks++; if (r_prog !== 4'(mRprog) || done !== mDone) begin errors++; $display("[TB] FAIL midreset_req1 i=%0d rprog=%0d done=%b exp %0d/%b", i, r_prog, done, mRprog, mDone); end
            if (i == 12) begin
                checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL midreset_done_t12 got=%b exp=1", done); end
            end
        end
    endtask

    task automatic test_retarget();
        int  doneCount = 0;
        int  maxCode   = 0;
        bit  acc;
        rst_n = 1'b0;
        clockEdge();
        rst_n = 1'b1;
        req_valid = 1'b1; req_code = 4'd8;
        clockEdge();
        req_valid = 1'b0;
        for (int i = 1; i <= 90; i++) begin
            acc = req_valid && (RETARGET || !mActive);
            clockEdge();
            if (acc) req_valid = 1'b0;
            if (i == 12) begin req_valid = 1'b1; req_code = 4'd1; end
            doneCount += int'(done);
            if (i > 12 && int'(r_prog) > maxCode) maxCode = int'(r_prog);
            checks++; if (r_prog !== 4'(mRprog)) begin errors++; $display("[TB] FAIL retgt_rprog i=%0d got=%0d exp=%0d", i, r_prog, mRprog); end
            checks++; if (done !== mDone || busy !== mActive) begin errors++; $display("[TB] FAIL retgt_flags i=%0d done=%b busy=%b exp %b/%b", i, done, busy, mDone, mActive); end
            checks++; if (req_ready !== (RETARGET || !mActive)) begin errors++; $display("[TB] FAIL retgt_ready i=%0d got=%b", i, req_ready); end
`ifdef RPROG_RETARGET_EN
            if (i == 29) begin
                checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL retgt_done_t29 got=%b exp=1", done); end
            end
`else
            if (i == 40 || i == 77) begin
                checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL blocked_done i=%0d got=%b exp=1", i, done); end
            end
`endif
        end
`ifdef RPROG_RETARGET_EN
        checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL retgt_done_count got=%0d exp=1", doneCount); end
        checks++; if (maxCode > 3) begin errors++; $display("[TB] FAIL retgt_overshoot got=%0d exp<=3", maxCode); end
`else
        checks++; if (doneCount != 2) begin errors++; $display("[TB] FAIL blocked_done_count got=%0d exp=2", doneCount); end
`endif
        checks++; if (r_prog !== 4'd1) begin errors++; $display("[TB] FAIL retgt_final got=%0d exp=1", r_prog); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 5) == 0);
            req_code  = 4'($urandom_range(0, 15));
            hold      = ($urandom_range(0, 3) == 0);
            clockEdge();
            checks++; if (r_prog !== 4'(mRprog)) begin errors++; $display("[TB] FAIL rand_rprog i=%0d got=%0d exp=%0d", i, r_prog, mRprog); end
            checks++; if (done !== mDone) begin errors++; $display("[TB] FAIL rand_done i=%0d got=%b exp=%b", i, done, mDone); end
            checks++; if (busy !== mActive) begin errors++; $display("[TB] FAIL rand_busy i=%0d got=%b exp=%b", i, busy, mActive); end
            checks++; if (req_ready !== (RETARGET || !mActive)) begin errors++; $display("[TB] FAIL rand_ready i=%0d got=%b", i, req_ready); end
        end
        req_valid = 1'b0;
        hold      = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_same_code();
        test_ramp_down();
        test_hold();
        test_reset_mid_ramp();
        test_retarget();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
